io_input_buffer: RTL and testbench
==================================

# io_input_buffer

Buffered input port sitting directly upstream of the `cpu` core's `input_data`/`input_ready` pins. It accepts words from an external producer over a valid/ready handshake and queues them in a small FIFO. It presents the oldest word to the core with `input_ready` high, and retires that word when the core pulses `input_ack` on executing an input instruction. This replaces driving `input_data`/`input_ready` straight from a switch bank or bench register, so back-to-back inputs are never lost.

## Interface
- `WIDTH`, default 32: data word width; must match the core's `input_data` width.
- `DEPTH`, default 4: FIFO capacity in words; power of two, at least 2.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `ext_data`  in  WIDTH  word offered by the external producer.
- `ext_valid`  in  1  producer has a word on `ext_data`.
- `ext_ready`  out  1  buffer can accept a word this cycle.
- `input_data`  out  WIDTH  head-of-queue word, to the core's `input_data`.
- `input_ready`  out  1  head word is valid, to the core's `input_ready`.
- `input_ack`  in  1  one-cycle pulse from the core: head word consumed.
- `count`  out  $clog2(DEPTH)+1  number of words currently held.
- `underflow`  out  1  sticky error: `input_ack` was seen while empty.

## Operation
- Storage:
  - Circular buffer of DEPTH words.
  - Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter `count`, range 0..DEPTH.
- Push:
  - A push occurs when `ext_valid && ext_ready` at a rising edge.
  - The word is stored at `wp`, then `wp` increments.
- Pop:
  - A pop occurs when `input_ack && input_ready` at a rising edge.
  - `rp` increments.
- Flags and outputs:
  - `ext_ready` = (`count` != DEPTH). It is combinational from state only and never depends on `ext_valid`.
  - `input_ready` = (`count` != 0).
  - `input_data` = mem[`rp`]. It is held stable while `input_ready` is high and no pop occurs.
- Simultaneous push and pop:
  - Both occur in the same edge and `count` is unchanged.
  - With `count`==1, the pushed word becomes the head on the next cycle.
  - With `count`==DEPTH, no push is possible because `ext_ready` is low; the pop alone proceeds.
- Full: `ext_valid` is ignored and the producer must hold its word (standard valid/ready). No data is dropped.
- Empty ack: `input_ack` with `count`==0 does not change pointers or `count`, and sets `underflow`.
- `underflow` clears only on `rst`.
- `input_data` while empty: value is don't-care; the bench must not check it.
- Reset:
  - `rst` asserted at any time, including mid-handshake, clears `wp`, `rp`, `count` and `underflow` immediately (asynchronously).
  - Contents of mem are not cleared.
  - Outputs during and after reset: `ext_ready`=1, `input_ready`=0, `count`=0, `underflow`=0.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge N on an empty buffer gives `input_ready`=1 with that word on `input_data` after edge N.
- No combinational path from `ext_data` or `ext_valid` to `input_data` or `input_ready`: there is no bypass.
- Pop-to-next-head is 1 cycle. After an ack at edge N, the next word (if any) is on `input_data` after edge N.
- Throughput is one push and one pop per cycle sustained.
- `count`, `ext_ready` and `input_ready` are all registered-state decodes, valid right after each edge.
- `input_ack` is sampled only at clock edges. A multi-cycle high `input_ack` pops once per cycle.

## Structure
- Shared package `cpu_io_pkg`:
  - `WORD_WIDTH` = 32, also used by the core.
  - Typedef `word_t` as logic [WORD_WIDTH-1:0].
- Sub-module `fifo_ram` holds the storage array:
  - One synchronous write port.
  - One asynchronous read port indexed by `rp`.
- Pointers, counter, flags and handshake logic remain in `io_input_buffer`.

## Test plan
- Reset and single word:
  - Stimulus: hold `rst` for 3 cycles, then push 5 with `ext_valid` for one cycle.
  - Required: during reset `input_ready`=0, `ext_ready`=1, `count`=0. After the push edge, `input_ready`=1, `input_data`=5, `count`=1.
  - Then pulse `input_ack`: `input_ready`=0 and `count`=0.
- Fill to full:
  - Stimulus: push 1,2,3,4 back-to-back (DEPTH=4) with no ack, then keep `ext_valid` high with 9.
  - Required: `ext_ready`=0 and `count`=4, and 9 is not stored.
  - Then ack once: next cycle `ext_ready`=1, 9 is accepted, and the drain order is 2,3,4,9.
- Simultaneous push and pop:
  - Stimulus: with `count`=1 (head 7), push 8 and ack in the same cycle.
  - Required: `count` stays 1 and `input_data`=8.
- Wrap-around:
  - Stimulus: stream 10 words (100..109) with ack every other cycle.
  - Required: output order is 100..109 exactly, and `count` never exceeds 4.
- Underflow:
  - Stimulus: ack while empty.
  - Required: `underflow`=1, `count` stays 0, and the next push of 3 is still read as 3. `underflow` clears only after `rst`.
- Reset mid-operation:
  - Stimulus: with `count`=3, assert `rst` asynchronously between edges.
  - Required: `count`=0 and `input_ready`=0 immediately, before the next edge.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Types and constants shared between the cpu core and its I/O blocks.
//   WORD_WIDTH : native data word width of the core's input/output pins.
//   word_t     : one data word as seen on the core's input_data pins.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : cpu_io_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Storage array for the input buffer.
// It has one synchronous write port and one asynchronous read port.
// The contents are never reset. Entries are only read back once the
// owning FIFO has written them.
// Ports:
//   clk      : system clock (write port)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (combinational read)
//   rdata_o  : read data, mem[raddr_i]
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read is asynchronous, so the head word appears on the same
  // cycle that the read pointer moves.
  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/io_input_buffer.sv
// -----------------------------------------------------------------------------
// io_input_buffer
// This is a buffered input port in front of the cpu core's input_data and
// input_ready pins. An external producer pushes words over a valid/ready
// handshake into a DEPTH-entry circular FIFO. The oldest word is presented
// to the core, and it is retired when the core pulses input_ack.
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   ext_data    : producer word
//   ext_valid   : producer has a word
//   ext_ready   : buffer not full (state decode only)
//   input_data  : head-of-queue word (don't-care while empty)
//   input_ready : buffer not empty
//   input_ack   : core consumed the head word
//   count       : words currently held, 0..DEPTH
//   underflow   : sticky; input_ack seen while empty, cleared by rst only
// -----------------------------------------------------------------------------
module io_input_buffer
  import cpu_io_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ext_valid,
  output logic             ext_ready,
  output logic [WIDTH-1:0] input_data,
  output logic             input_ready,
  input  logic             input_ack,
  output logic [CW-1:0]    count,
  output logic             underflow
);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          underflow_q, underflow_d;

  logic push;
  logic pop;

  // The flags decode registered state only. There is no path from
  // ext_valid or ext_data to the core-side outputs.
  assign ext_ready   = (count_q != FULL_COUNT);
  assign input_ready = (count_q != CNT_ZERO);

  assign push = ext_valid && ext_ready;
  assign pop  = input_ack && input_ready;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    // DEPTH is a power of two, so the natural pointer overflow is the
    // modulo-DEPTH wrap.
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;

    // A push and a pop on the same edge leave the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (input_ack && !input_ready) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (ext_data),
    .raddr_i (rp_q),
    .rdata_o (input_data)
  );

  assign count     = count_q;
  assign underflow = underflow_q;

endmodule : io_input_buffer

// File: tb/tb_io_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_io_input_buffer
// Directed self-checking bench for io_input_buffer (WIDTH=32, DEPTH=4).
// Inputs are driven 1 time unit after each rising edge.
// Outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_io_input_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] ext_data;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] input_data;
  logic        input_ready;
  logic        input_ack;
  logic [2:0]  count;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  io_input_buffer #(
    .WIDTH (32),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_data    (ext_data),
    .ext_valid   (ext_valid),
    .ext_ready   (ext_ready),
    .input_data  (input_data),
    .input_ready (input_ready),
    .input_ack   (input_ack),
    .count       (count),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_data = '0; ext_valid = 1'b0; input_ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (input_ready !== 1'b0 || ext_ready !== 1'b1 || count !== 3'd0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: ready=%b ext_ready=%b count=%0d uf=%b, required 0 1 0 0",
                 i, input_ready, ext_ready, count, underflow);
      end
      step();
    end
    rst = 1'b0;
    ext_data = 32'd5; ext_valid = 1'b1;
    step();
    ext_valid = 1'b0;
    checks++;
    if (input_ready !== 1'b1 || input_data !== 32'd5 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: ready=%b data=%0d count=%0d, required 1 5 1", input_ready, input_data, count);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    checks++;
    if (input_ready !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: ready=%b count=%0d, required 0 0", input_ready, count);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    int exp_order [4] = '{2, 3, 4, 9};
    for (int i = 1; i <= 4; i++) begin
      ext_data = 32'(i); ext_valid = 1'b1;
      step();
    end
    checks++;
    if (ext_ready !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full_flag: ext_ready=%b count=%0d, required 0 4", ext_ready, count);
    end
    // The producer holds 9 against a full buffer, and it must not be stored.
    ext_data = 32'd9;
    step();
    checks++;
    if (ext_ready !== 1'b0 || count !== 3'd4 || input_data !== 32'd1) begin
      errors++;
      $display("FAIL full_hold: ext_ready=%b count=%0d head=%0d, required 0 4 1", ext_ready, count, input_data);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    checks++;
    if (ext_ready !== 1'b1 || count !== 3'd3 || input_data !== 32'd2) begin
      errors++;
      $display("FAIL full_pop: ext_ready=%b count=%0d head=%0d, required 1 3 2", ext_ready, count, input_data);
    end
    step();
    ext_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_accept9: count=%0d, required 4", count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (input_ready !== 1'b1 || input_data !== 32'(exp_order[k])) begin
        errors++;
        $display("FAIL drain[%0d]: ready=%b data=%0d, required 1 %0d", k, input_ready, input_data, exp_order[k]);
      end
      input_ack = 1'b1;
      step();
    end
    input_ack = 1'b0;
    checks++;
    if (count !== 3'd0 || input_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d ready=%b, required 0 0", count, input_ready);
    end
    $display("test_fill done");
  endtask

  task automatic test_simultaneous();
    ext_data = 32'd7; ext_valid = 1'b1;
    step();
    checks++;
    if (count !== 3'd1 || input_data !== 32'd7) begin
      errors++;
      $display("FAIL simul_setup: count=%0d head=%0d, required 1 7", count, input_data);
    end
    ext_data = 32'd8; input_ack = 1'b1;
    step();
    ext_valid = 1'b0; input_ack = 1'b0;
    checks++;
    if (count !== 3'd1 || input_ready !== 1'b1 || input_data !== 32'd8) begin
      errors++;
      $display("FAIL simul_push_pop: count=%0d ready=%b head=%0d, required 1 1 8", count, input_ready, input_data);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL simul_drain: count=%0d, required 0", count);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    int model_count = 0;
    int cyc = 0;
    bit do_push, do_pop;
    while (popped < 10 && cyc < 100) begin
      ext_valid = (pushed < 10);
      ext_data  = 32'(100 + pushed);
      input_ack = cyc[0] && (model_count != 0);
      do_push = ext_valid && (model_count != 4);
      do_pop  = input_ack;
      if (do_pop) begin
        checks++;
        if (input_data !== 32'(100 + popped)) begin
          errors++;
          $display("FAIL wrap_order[%0d]: data=%0d, required %0d", popped, input_data, 100 + popped);
        end
      end
      step();
      if (do_push) pushed++;
      if (do_pop) popped++;
      model_count = model_count + int'(do_push) - int'(do_pop);
      checks++;
      if (count !== 3'(model_count) || count > 3'd4) begin
        errors++;
        $display("FAIL wrap_count cyc=%0d: count=%0d, required %0d", cyc, count, model_count);
      end
      cyc++;
    end
    ext_valid = 1'b0; input_ack = 1'b0;
    checks++;
    if (popped != 10) begin
      errors++;
      $display("FAIL wrap_timeout: popped=%0d, required 10", popped);
    end
    $display("test_wrap done (%0d cycles)", cyc);
  endtask

  task automatic test_underflow();
    checks++;
    if (underflow !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL uf_pre: uf=%b count=%0d, required 0 0", underflow, count);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    checks++;
    if (underflow !== 1'b1 || count !== 3'd0 || input_ready !== 1'b0) begin
      errors++;
      $display("FAIL uf_set: uf=%b count=%0d ready=%b, required 1 0 0", underflow, count, input_ready);
    end
    ext_data = 32'd3; ext_valid = 1'b1;
    step();
    ext_valid = 1'b0;
    checks++;
    if (input_data !== 32'd3 || count !== 3'd1 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_push: data=%0d count=%0d uf=%b, required 3 1 1", input_data, count, underflow);
    end
    input_ack = 1'b1;
    step();
    input_ack = 1'b0;
    checks++;
    if (count !== 3'd0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: count=%0d uf=%b, required 0 1", count, underflow);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: uf=%b, required 0", underflow);
    end
    step();
    rst = 1'b0;
    $display("test_underflow done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      ext_data = 32'(11 + i); ext_valid = 1'b1;
      step();
    end
    ext_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL mid_setup: count=%0d, required 3", count);
    end
    #2;
    rst = 1'b1;
    #1;
    // This check runs before the next rising edge, so only an asynchronous reset can satisfy it.
    checks++;
    if (count !== 3'd0 || input_ready !== 1'b0 || ext_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: count=%0d ready=%b ext_ready=%b, required 0 0 1", count, input_ready, ext_ready);
    end
    step();
    rst = 1'b0;
    ext_data = 32'd20; ext_valid = 1'b1;
    step();
    ext_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || input_data !== 32'd20) begin
      errors++;
      $display("FAIL mid_after: count=%0d data=%0d, required 1 20", count, input_data);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_underflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_io_input_buffer
